// File: rtl/sap_pkg.sv
// SAP-1 controller-sequencer shared definitions: opcodes, control-bit
// positions, microword constants and the one-hot ring state encoding.
package sap_pkg;

  localparam int OPCODE_W = 4;
  localparam int T_STATES = 6;
  localparam int CW_W     = 12;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [CW_W-1:0]     cw_t;

  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  // Control word bit positions, MSB first: {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  // All active-low enables deasserted, all active-high enables low.
  localparam cw_t CW_INACTIVE = 12'h3E3;

  // Fetch cycle, common to every instruction.
  localparam cw_t CW_T1 = 12'h5E3;  // Ep, Lm_n: PC -> MAR
  localparam cw_t CW_T2 = 12'hBE3;  // Cp: increment PC
  localparam cw_t CW_T3 = 12'h263;  // CE_n, Li_n: RAM -> IR

  // Execute microwords.
  localparam cw_t CW_MEM_T4 = 12'h1A3;  // Lm_n, Ei_n: IR operand -> MAR (LDA/ADD/SUB)
  localparam cw_t CW_LDA_T5 = 12'h2C3;  // CE_n, La_n: RAM -> A
  localparam cw_t CW_LDA_T6 = 12'h3E3;
  localparam cw_t CW_ALU_T5 = 12'h2E1;  // CE_n, Lb_n: RAM -> B
  localparam cw_t CW_ADD_T6 = 12'h3C7;  // La_n, Eu: A+B -> A
  localparam cw_t CW_SUB_T6 = 12'h3CF;  // La_n, Eu, Su: A-B -> A
  localparam cw_t CW_OUT_T4 = 12'h3F2;  // Ea, Lo_n: A -> OUT

  // One-hot ring; all-zero only after HLT.
  typedef enum logic [T_STATES-1:0] {
    T_HALT = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } ring_t;

  // Last T-state that does useful work for an opcode; undefined opcodes end
  // with the fetch. HLT never reaches its wrap point because it halts at T4.
  function automatic ring_t last_step(opcode_t op);
    case (op)
      OP_LDA:         return T5;
      OP_ADD, OP_SUB: return T6;
      OP_OUT:         return T4;
      OP_HLT:         return T6;
      default:        return T3;
    endcase
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// SAP-1 one-hot T-state ring. Advances on the falling clock edge so the
// decoded control word is stable before the rising-edge register loads.
// halt_req parks the ring at all-zero until reset; wrap_req returns to T1
// early (variable-length microcode).
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  step_en,
  input  logic  halt_req,
  input  logic  wrap_req,
  output ring_t state,
  output logic  halted
);

  // Ring advance / halt on falling edge; reset aborts any instruction in flight.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted && step_en) begin
      if (halt_req) begin
        state  <= T_HALT;
        halted <= 1'b1;
      end else if (wrap_req) begin
        state <= T1;
      end else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          T6:      state <= T1;
          default: state <= T1;
        endcase
      end
    end
  end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer top: microcode decode and halt detection around
// the one-hot ring counter. Build option SAP_SEQ_VARIABLE_MC_EN shortens each
// instruction to its last active microstep; without it every instruction
// takes six T-states. T_STATES is fixed at 6.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = sap_pkg::OPCODE_W,
  parameter int T_STATES = sap_pkg::T_STATES,
  parameter int CW_W     = sap_pkg::CW_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_en,
  input  logic [OPCODE_W-1:0] instr_opcode,
  output logic [CW_W-1:0]     control_word,
  output logic [T_STATES-1:0] t_state,
  output logic                halted
);

  ring_t ring;
  logic  halt_req;
  logic  wrap_req;

  sap_ring_counter u_ring (
    .clk      (clk),
    .reset    (reset),
    .step_en  (step_en),
    .halt_req (halt_req),
    .wrap_req (wrap_req),
    .state    (ring),
    .halted   (halted)
  );

  assign t_state = ring;

`ifdef SAP_SEQ_VARIABLE_MC_EN
  opcode_t op_latched;

  // Capture the opcode on the rising edge that loads IR during T3; the wrap
  // decision for the rest of the instruction is made from this copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_latched <= OP_LDA;
    end else if (ring == T3) begin
      op_latched <= instr_opcode;
    end
  end

  assign wrap_req = (ring == last_step(op_latched));
`else
  assign wrap_req = 1'b0;
`endif

  // Microcode decode: word follows the live opcode during T4..T6; HLT at T4
  // requests the halt that the ring applies on the next stepping edge.
  always_comb begin
    control_word = CW_INACTIVE;
    halt_req     = 1'b0;
    case (ring)
      T1: control_word = CW_T1;
      T2: control_word = CW_T2;
      T3: control_word = CW_T3;
      T4: begin
        case (instr_opcode)
          OP_LDA, OP_ADD, OP_SUB: control_word = CW_MEM_T4;
          OP_OUT:                 control_word = CW_OUT_T4;
          OP_HLT:                 halt_req     = 1'b1;
          default:                control_word = CW_INACTIVE;
        endcase
      end
      T5: begin
        case (instr_opcode)
          OP_LDA:         control_word = CW_LDA_T5;
          OP_ADD, OP_SUB: control_word = CW_ALU_T5;
          default:        control_word = CW_INACTIVE;
        endcase
      end
      T6: begin
        case (instr_opcode)
          OP_LDA:  control_word = CW_LDA_T6;
          OP_ADD:  control_word = CW_ADD_T6;
          OP_SUB:  control_word = CW_SUB_T6;
          default: control_word = CW_INACTIVE;
        endcase
      end
      default: control_word = CW_INACTIVE;
    endcase
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer. Honors
// SAP_SEQ_VARIABLE_MC_EN to select the expected instruction lengths.
module tb_sap_controller_sequencer;

  logic        clk;
  logic        reset;
  logic        step_en;
  logic [3:0]  instr_opcode;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halted;

  typedef struct {
    logic [5:0]  t;
    logic [11:0] cw;
    logic        h;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        en;
    logic [5:0]  t;
    logic [11:0] cw;
    logic        h;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  sap_controller_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .step_en      (step_en),
    .instr_opcode (instr_opcode),
    .control_word (control_word),
    .t_state      (t_state),
    .halted       (halted)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got t_state=%b cw=%h halted=%b",
               name, t_state, control_word, halted);
    end else begin
      e = sb.pop_front();
      if (t_state !== e.t || control_word !== e.cw || halted !== e.h) begin
        n_err++;
        $display("FAIL %s: got t_state=%b cw=%h halted=%b, want t_state=%b cw=%h halted=%b",
                 name, t_state, control_word, halted, e.t, e.cw, e.h);
      end
    end
  endtask

  task automatic expect_now(string name, logic [5:0] t, logic [11:0] cw, logic h);
    exp_t e;
    e.t = t; e.cw = cw; e.h = h;
    sb.push_back(e);
    check(name);
  endtask

  // Drive inputs, queue expectation for after the next falling edge, then check.
  task automatic step(string name, logic [3:0] op, logic en,
                      logic [5:0] t, logic [11:0] cw, logic h);
    exp_t e;
    instr_opcode = op;
    step_en      = en;
    e.t = t; e.cw = cw; e.h = h;
    sb.push_back(e);
    @(negedge clk);
    #2;
    check(name);
  endtask

  task automatic do_reset();
    step_en = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic v(logic [3:0] op, logic en, logic [5:0] t, logic [11:0] cw, logic h);
    vec_t x;
    x.op = op; x.en = en; x.t = t; x.cw = cw; x.h = h;
    vecs.push_back(x);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    step_en      = 1'b0;
    instr_opcode = 4'b0000;

    // Vector table, applied consecutively from T1.
    // ADD with junk opcodes during fetch
    v(4'b1111, 1, 6'b000010, 12'hBE3, 0);
    v(4'b0110, 1, 6'b000100, 12'h263, 0);
    v(4'b0001, 1, 6'b001000, 12'h1A3, 0);
    v(4'b0001, 1, 6'b010000, 12'h2E1, 0);
    v(4'b0001, 1, 6'b100000, 12'h3C7, 0);
    v(4'b0001, 1, 6'b000001, 12'h5E3, 0);
    // SUB with a held edge in T3
    v(4'b0010, 1, 6'b000010, 12'hBE3, 0);
    v(4'b0010, 1, 6'b000100, 12'h263, 0);
    v(4'b0010, 0, 6'b000100, 12'h263, 0);
    v(4'b0010, 1, 6'b001000, 12'h1A3, 0);
    v(4'b0010, 1, 6'b010000, 12'h2E1, 0);
    v(4'b0010, 1, 6'b100000, 12'h3CF, 0);
    v(4'b0010, 1, 6'b000001, 12'h5E3, 0);
    // LDA
    v(4'b0000, 1, 6'b000010, 12'hBE3, 0);
    v(4'b0000, 1, 6'b000100, 12'h263, 0);
    v(4'b0000, 1, 6'b001000, 12'h1A3, 0);
    v(4'b0000, 1, 6'b010000, 12'h2C3, 0);
`ifndef SAP_SEQ_VARIABLE_MC_EN
    v(4'b0000, 1, 6'b100000, 12'h3E3, 0);
`endif
    v(4'b0000, 1, 6'b000001, 12'h5E3, 0);
    // OUT
    v(4'b1110, 1, 6'b000010, 12'hBE3, 0);
    v(4'b1110, 1, 6'b000100, 12'h263, 0);
    v(4'b1110, 1, 6'b001000, 12'h3F2, 0);
`ifndef SAP_SEQ_VARIABLE_MC_EN
    v(4'b1110, 1, 6'b010000, 12'h3E3, 0);
    v(4'b1110, 1, 6'b100000, 12'h3E3, 0);
`endif
    v(4'b1110, 1, 6'b000001, 12'h5E3, 0);
    // undefined opcode 0101 behaves as NOP
    v(4'b0101, 1, 6'b000010, 12'hBE3, 0);
    v(4'b0101, 1, 6'b000100, 12'h263, 0);
`ifndef SAP_SEQ_VARIABLE_MC_EN
    v(4'b0101, 1, 6'b001000, 12'h3E3, 0);
    v(4'b0101, 1, 6'b010000, 12'h3E3, 0);
    v(4'b0101, 1, 6'b100000, 12'h3E3, 0);
`endif
    v(4'b0101, 1, 6'b000001, 12'h5E3, 0);

    // Reset state, checked while reset is still asserted.
    #2;
    expect_now("reset_asserted", 6'b000001, 12'h5E3, 1'b0);
    do_reset();
    expect_now("after_reset", 6'b000001, 12'h5E3, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].en, vecs[i].t, vecs[i].cw, vecs[i].h);
    end

    // Word follows opcode within T5, then reset mid-instruction.
    step("add_t2", 4'b0001, 1, 6'b000010, 12'hBE3, 0);
    step("add_t3", 4'b0001, 1, 6'b000100, 12'h263, 0);
    step("add_t4", 4'b0001, 1, 6'b001000, 12'h1A3, 0);
    step("add_t5", 4'b0001, 1, 6'b010000, 12'h2E1, 0);
    instr_opcode = 4'b0000;
    #1;
    expect_now("t5_follows_lda", 6'b010000, 12'h2C3, 1'b0);
    instr_opcode = 4'b0001;
    #1;
    expect_now("t5_follows_add", 6'b010000, 12'h2E1, 1'b0);
    reset = 1'b1;
    #1;
    expect_now("reset_mid_t5", 6'b000001, 12'h5E3, 1'b0);
    step_en = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
    expect_now("post_abort_t1", 6'b000001, 12'h5E3, 1'b0);

    // Single-step hold in T3 for five clocks.
    step("hold_t2", 4'b0010, 1, 6'b000010, 12'hBE3, 0);
    step("hold_t3", 4'b0010, 1, 6'b000100, 12'h263, 0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("hold_%0d", i), 4'b0010, 0, 6'b000100, 12'h263, 0);
    end
    step("hold_release_t4", 4'b0010, 1, 6'b001000, 12'h1A3, 0);
    step("hold_t5", 4'b0010, 1, 6'b010000, 12'h2E1, 0);
    step("hold_t6", 4'b0010, 1, 6'b100000, 12'h3CF, 0);
    step("hold_t1", 4'b0010, 1, 6'b000001, 12'h5E3, 0);

    // HLT: held T4 does not halt; the stepping T4 edge does, then nothing moves.
    step("hlt_t2", 4'b1111, 1, 6'b000010, 12'hBE3, 0);
    step("hlt_t3", 4'b1111, 1, 6'b000100, 12'h263, 0);
    step("hlt_t4", 4'b1111, 1, 6'b001000, 12'h3E3, 0);
    step("hlt_t4_held", 4'b1111, 0, 6'b001000, 12'h3E3, 0);
    step("hlt_halt", 4'b1111, 1, 6'b000000, 12'h3E3, 1);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("halted_%0d", i), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           6'b000000, 12'h3E3, 1);
    end
    reset = 1'b1;
    #1;
    expect_now("reset_from_halt", 6'b000001, 12'h5E3, 1'b0);
    do_reset();
    step("restart_t2", 4'b0001, 1, 6'b000010, 12'hBE3, 0);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
